// File: rtl/eth_mdio_pkg.sv
// eth_mdio_pkg: controller state encoding, BMSR constants and init-table record.
// Shared by eth_mdio_ctrl and eth_mdio_init_rom.
package eth_mdio_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_INIT_WAIT,
        S_IDLE,
        S_USR_WAIT,
        S_POLL_WAIT
    } state_t;

    localparam logic [4:0] REG_BMSR      = 5'h01;
    localparam int         BMSR_LINK_BIT = 2;

    typedef struct packed {
        logic [4:0]  areg;
        logic [15:0] data;
    } init_entry_t;

endpackage

// File: rtl/eth_mdio_init_rom.sv
// eth_mdio_init_rom: combinational PHY init write table, looked up by entry index.
// Indices beyond the populated entries return a zero record.
module eth_mdio_init_rom
    import eth_mdio_pkg::*;
(
    input  logic [3:0]  i_idx,
    output init_entry_t o_entry
);

    always_comb begin
        case (i_idx)
            4'd0:    o_entry = '{areg: 5'h00, data: 16'h8000};
            4'd1:    o_entry = '{areg: 5'h04, data: 16'h01E1};
            4'd2:    o_entry = '{areg: 5'h09, data: 16'h0300};
            4'd3:    o_entry = '{areg: 5'h00, data: 16'h1200};
            default: o_entry = '{areg: 5'h00, data: 16'h0000};
        endcase
    end

endmodule

// File: rtl/eth_mdio_ctrl.sv
// eth_mdio_ctrl: PHY management sequencer -- init table, user access, periodic BMSR link poll.
// Link polling is compiled in only when ETH_MDIO_POLL_EN is defined.
module eth_mdio_ctrl
    import eth_mdio_pkg::*;
#(
    parameter logic [4:0] G_PHY_ADDR    = 5'h06,
    parameter int         G_INIT_CNT    = 4,
    parameter int         G_POLL_PERIOD = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        usr_req,
    input  logic        usr_dir,
    input  logic [4:0]  usr_areg,
    input  logic [15:0] usr_txd,
    output logic [15:0] usr_rxd,
    output logic        usr_ack,
    output logic        usr_busy,
    output logic        mdio_start,
    output logic        mdio_dir,
    output logic [4:0]  mdio_aphy,
    output logic [4:0]  mdio_areg,
    output logic [15:0] mdio_txd,
    input  logic [15:0] mdio_rxd,
    input  logic        mdio_done,
    input  logic        mdio_busy,
    output logic        init_done,
    output logic        link_up,
    output logic [15:0] poll_cnt
);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_idx;
    init_entry_t w_entry;
    logic        w_issue, w_dir, w_init_step, w_usr_done, w_poll_pending;
    logic        w_init_last;
    logic [4:0]  w_areg;
    logic [15:0] w_txd;
    logic        r_start, r_dir, r_ack, r_busy, r_init_done;
    logic [4:0]  r_aphy, r_areg;
    logic [15:0] r_txd, r_usr_rxd;

    eth_mdio_init_rom u_rom (
        .i_idx   (r_idx),
        .o_entry (w_entry)
    );

    assign w_init_last = (r_idx == 4'(G_INIT_CNT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_dir       = 1'b1;
        w_areg      = w_entry.areg;
        w_txd       = w_entry.data;
        w_init_step = 1'b0;
        w_usr_done  = 1'b0;
        case (r_state)
            S_INIT: if (!mdio_busy) begin
                w_issue     = 1'b1;
                w_state_nxt = S_INIT_WAIT;
            end
            S_INIT_WAIT: if (mdio_done) begin
                w_init_step = 1'b1;
                w_state_nxt = w_init_last ? S_IDLE : S_INIT;
            end
            S_IDLE: if (usr_req && !mdio_busy) begin
                w_issue     = 1'b1;
                w_dir       = usr_dir;
                w_areg      = usr_areg;
                w_txd       = usr_txd;
                w_state_nxt = S_USR_WAIT;
            end else if (w_poll_pending && !mdio_busy) begin
                w_issue     = 1'b1;
                w_dir       = 1'b0;
                w_areg      = REG_BMSR;
                w_txd       = '0;
                w_state_nxt = S_POLL_WAIT;
            end
            S_USR_WAIT: if (mdio_done) begin
                w_usr_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_POLL_WAIT: if (mdio_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_idx       <= '0;
            r_start     <= 1'b0;
            r_dir       <= 1'b0;
            r_aphy      <= '0;
            r_areg      <= '0;
            r_txd       <= '0;
            r_usr_rxd   <= '0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_issue;
            r_ack   <= w_usr_done;
            r_busy  <= (w_state_nxt == S_USR_WAIT);
            if (w_issue) begin
                r_dir  <= w_dir;
                r_aphy <= G_PHY_ADDR;
                r_areg <= w_areg;
                r_txd  <= w_txd;
            end
            if (w_init_step && !w_init_last) r_idx <= r_idx + 4'd1;
            if (w_init_step && w_init_last) r_init_done <= 1'b1;
            if (w_usr_done && !r_dir) r_usr_rxd <= mdio_rxd;
        end
    end

`ifdef ETH_MDIO_POLL_EN
    logic [31:0] r_timer;
    logic        r_poll_pending, r_link_up;
    logic [15:0] r_poll_cnt;
    logic        w_wrap, w_poll_take, w_poll_done;

    assign w_wrap      = r_init_done && (r_timer == 32'(G_POLL_PERIOD - 1));
    assign w_poll_take = w_issue && (w_state_nxt == S_POLL_WAIT);
    assign w_poll_done = (r_state == S_POLL_WAIT) && mdio_done;

    // A wrap landing while a poll is already pending just merges into it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer        <= '0;
            r_poll_pending <= 1'b0;
            r_link_up      <= 1'b0;
            r_poll_cnt     <= '0;
        end else begin
            if (r_init_done) r_timer <= w_wrap ? '0 : r_timer + 32'd1;
            if (w_wrap) r_poll_pending <= 1'b1;
            else if (w_poll_take) r_poll_pending <= 1'b0;
            if (w_poll_done) begin
                r_link_up  <= mdio_rxd[BMSR_LINK_BIT];
                r_poll_cnt <= r_poll_cnt + 16'd1;
            end
        end
    end

    assign w_poll_pending = r_poll_pending;
    assign link_up        = r_link_up;
    assign poll_cnt       = r_poll_cnt;
`else
    assign w_poll_pending = 1'b0;
    assign link_up        = 1'b0;
    assign poll_cnt       = '0;
`endif

    assign mdio_start = r_start;
    assign mdio_dir   = r_dir;
    assign mdio_aphy  = r_aphy;
    assign mdio_areg  = r_areg;
    assign mdio_txd   = r_txd;
    assign usr_rxd    = r_usr_rxd;
    assign usr_ack    = r_ack;
    assign usr_busy   = r_busy;
    assign init_done  = r_init_done;

endmodule

// File: doc/eth_mdio_ctrl.md
ETH_MDIO_CTRL -- requirements
Module: eth_mdio_ctrl

Interface
REQ-001 SHALL have parameter G_PHY_ADDR, default 5'h06, PHY address used for every transaction.
REQ-002 SHALL have parameter G_INIT_CNT, default 4, number of init-table write entries (1..16).
REQ-003 SHALL have parameter G_POLL_PERIOD, default 1000000, clk cycles between link-status polls (min 64).
REQ-004 SHALL have ports: clk  in  1  system clock; rst  in  1  asynchronous active-high reset (one clock; reset is asynchronous and active-high).
REQ-005 SHALL have user ports: usr_req in 1 request level; usr_dir in 1 1=write 0=read; usr_areg in 5 register address; usr_txd in 16 write data; usr_rxd out 16 read data; usr_ack out 1 one-cycle completion pulse; usr_busy out 1 user transaction in flight.
REQ-006 SHALL have MDIO-engine ports: mdio_start out 1; mdio_dir out 1; mdio_aphy out 5; mdio_areg out 5; mdio_txd out 16; mdio_rxd in 16; mdio_done in 1 (one-cycle pulse); mdio_busy in 1.
REQ-007 SHALL have status ports: init_done out 1 init table complete; link_up out 1 PHY link status; poll_cnt out 16 completed polls, wraps.

Function
REQ-008 SHALL implement states S_INIT, S_INIT_WAIT, S_IDLE, S_USR_WAIT, S_POLL_WAIT.
REQ-009 SHALL, after reset, leave S_INIT and issue init entries 0..G_INIT_CNT-1 in order as writes to G_PHY_ADDR.
REQ-010 SHALL assert mdio_start for exactly one cycle per transaction, with dir/aphy/areg/txd stable from that cycle until mdio_done.
REQ-011 SHALL issue a transaction only when mdio_busy=0, never more than one outstanding.
REQ-012 SHALL, on mdio_done in S_INIT_WAIT, advance index; after last entry set init_done=1 and enter S_IDLE.
REQ-013 SHALL ignore usr_req until init_done=1 (usr_busy stays 0).
REQ-014 SHALL in S_IDLE give priority user > poll; if usr_req=1 and mdio_busy=0, assert mdio_start next cycle and usr_busy=1.
REQ-015 SHALL, on mdio_done in S_USR_WAIT, capture mdio_rxd into usr_rxd (reads only; writes leave usr_rxd unchanged), pulse usr_ack one cycle, clear usr_busy, return to S_IDLE.
REQ-016 SHALL require usr_req to be deasserted the cycle after usr_ack or be treated as a new request.
REQ-017 SHALL run a poll timer counting up to G_POLL_PERIOD-1 from init_done; at wrap set poll_pending; timer keeps running during other transactions.
REQ-018 SHALL, when poll_pending and no usr_req in S_IDLE, read register 5'h01 (BMSR), clear poll_pending, enter S_POLL_WAIT.
REQ-019 SHALL on poll mdio_done set link_up=mdio_rxd[2] and increment poll_cnt (16'hFFFF wraps to 0).
REQ-020 SHALL, if usr_req and poll_pending coincide, serve user first, poll immediately after; a second timer wrap while pending is merged.

Reset
REQ-021 SHALL on rst force: state S_INIT, index 0, mdio_start 0, mdio_dir 0, mdio_aphy/areg 0, mdio_txd 0, usr_rxd 0, usr_ack 0, usr_busy 0, init_done 0, link_up 0, poll_cnt 0, timer 0, poll_pending 0.
REQ-022 SHALL on reset mid-transaction abandon it without ack and restart the init table after release.

Configuration
REQ-023 SHALL compile polling (REQ-017..020) only when ETH_MDIO_POLL_EN is defined; without it timer/poll logic is absent, link_up and poll_cnt are tied 0, S_POLL_WAIT unreachable.

Structure
REQ-024 SHALL place state encoding, REG_BMSR=5'h01, BMSR_LINK_BIT=2 and init-entry record (areg 5, data 16) in package eth_mdio_pkg.
REQ-025 SHALL implement init table as sub-module eth_mdio_init_rom (index in, areg/data out, combinational); default entries: {5'h00,16'h8000},{5'h04,16'h01E1},{5'h09,16'h0300},{5'h00,16'h1200}.

Verification
REQ-026 Reset release with engine model (done 40 cycles after start) -> four writes areg 00,04,09,00 data 8000,01E1,0300,1200 at aphy 06, then init_done=1.
REQ-027 usr_req during init -> no user transaction until init_done=1; then one write, usr_ack pulse once.
REQ-028 User read areg 5'h0B, model returns 16'h8FFA -> usr_rxd=16'h8FFA on usr_ack cycle, usr_busy low next cycle.
REQ-029 ETH_MDIO_POLL_EN, G_POLL_PERIOD=200, model BMSR=16'h7949 -> link_up=0; then 16'h796D -> link_up=1, poll_cnt increments per poll.
REQ-030 usr_req asserted same cycle as poll timer wrap -> user transaction first, BMSR read directly after.
REQ-031 rst pulsed mid user transaction -> no usr_ack, all outputs at reset values, init sequence reissued from entry 0.
